// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of the 8:1 mux directly upstream.
// One source is granted at a time; the selection is held until a valid/ready
// handshake completes or a watchdog abandons the grant.
module rr_mux_sel_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       out_valid,
  output logic [7:0] grant,
  output logic [7:0] ack,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [2:0] sel;
  logic [2:0] ptr;
  logic [7:0] wdog;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       found;

  assign {sel2, sel1, sel0} = sel;
  assign ack = grant & {8{out_valid & out_ready}};

  // Find the first requesting source, starting at ptr and wrapping 7->0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Arbitration FSM with registered select, grant, valid and timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      wdog      <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= pick;
            grant     <= 8'b1 << pick;
            out_valid <= 1'b1;
            wdog      <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (out_ready) begin
            ptr       <= sel + 3'd1;
            grant     <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (wdog == WDOG_LAST) begin
            timeout   <= 1'b1;
            ptr       <= sel + 3'd1;
            grant     <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
